// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the RV32I 5-stage core.
// Captures decoded instruction fields from ID and presents them to EX one
// cycle later. Inserts a bubble on load-use hazards and honours EX-side
// flush (highest priority) and hold requests.
// Optional feature macro: HAZARD_STATS_EN adds saturating counters of
// load-use bubbles and effective flushes (stat_stall_cnt / stat_flush_cnt).
module id_ex_reg #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_b5,
  input  logic [9:0]      id_ctrl,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_b5,
  output logic [9:0]      ex_ctrl
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cnt,
  output logic [STAT_W-1:0] stat_flush_cnt
`endif
);

  // ctrl = {reg_write,alu_src,mem_read,mem_write,mem_to_reg,branch,jump,alu_op[1:0]}
  localparam int unsigned MEM_READ_BIT = 7;

  if (STAT_W < 1) begin : g_bad_stat_w
    $error("STAT_W must be at least 1");
  end

  logic load_use;
  logic bubble;

  // Load in EX whose destination is read by the ID instruction (both sources, any opcode).
  always_comb begin
    load_use = id_valid & ex_valid & ex_ctrl[MEM_READ_BIT] & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    bubble   = ex_flush | (~ex_hold & load_use);
  end

  // Upstream stall; a flush lets IF/ID advance so the redirected path is fetched.
  assign stall_id = ex_valid & ~ex_flush & (ex_hold | load_use);

  // Pipeline register: flush > hold > load-use bubble > normal capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_rd        <= 5'd0;
      ex_funct3    <= 3'd0;
      ex_funct7_b5 <= 1'b0;
      ex_ctrl      <= 10'd0;
    end else if (bubble) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_rd        <= 5'd0;
      ex_funct3    <= 3'd0;
      ex_funct7_b5 <= 1'b0;
      ex_ctrl      <= 10'd0;
    end else if (!ex_hold) begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= id_imm;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_funct3    <= id_funct3;
      ex_funct7_b5 <= id_funct7_b5;
      ex_ctrl      <= id_valid ? id_ctrl : 10'd0;
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Saturating hazard statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cnt <= '0;
      stat_flush_cnt <= '0;
    end else begin
      if (~ex_flush & ~ex_hold & load_use & (stat_stall_cnt != STAT_MAX)) begin
        stat_stall_cnt <= stat_stall_cnt + STAT_W'(1);
      end
      if (ex_flush & (ex_valid | id_valid) & (stat_flush_cnt != STAT_MAX)) begin
        stat_flush_cnt <= stat_flush_cnt + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: instruction-slot model checked every cycle plus directed literal checks.
module tb_id_ex_reg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned STAT_W = 4;
  localparam int          STAT_MAXI = (1 << STAT_W) - 1;
  localparam logic [9:0]  C_LW  = 10'h3A0; // reg_write, alu_src, mem_read, mem_to_reg
  localparam logic [9:0]  C_ADD = 10'h202; // reg_write, alu_op=10

  logic clk, rst_n;
  logic id_valid, id_funct7_b5, ex_flush, ex_hold;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic [9:0] id_ctrl;
  logic stall_id, ex_valid, ex_funct7_b5;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [9:0] ex_ctrl;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stat_stall_cnt, stat_flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic last_stall;

  id_ex_reg #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .id_ctrl(id_ctrl), .ex_flush(ex_flush),
    .ex_hold(ex_hold), .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_b5(ex_funct7_b5), .ex_ctrl(ex_ctrl)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cnt(stat_stall_cnt), .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the instruction currently sitting in the EX slot.
  typedef struct packed {
    logic v;
    logic [31:0] pc, a, b, imm;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    logic f7;
    logic [9:0] ctrl;
  } slot_t;

  slot_t m;
  int m_stall, m_flush;
  logic m_lu, m_stall_id;

  // A load in EX writing a nonzero register that the ID instruction reads.
  assign m_lu = id_valid && m.v && m.ctrl[7] && m.rd != 5'd0 &&
                (m.rd == id_rs1 || m.rd == id_rs2);
  assign m_stall_id = m.v && !ex_flush && (ex_hold || m_lu);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      if (ex_flush || (!ex_hold && m_lu)) begin
        m.v <= 1'b0;
        m.ctrl <= 10'd0;
      end else if (!ex_hold) begin
        m <= '{v: id_valid, pc: id_pc, a: id_rs1_data, b: id_rs2_data, imm: id_imm,
               rs1: id_rs1, rs2: id_rs2, rd: id_rd, f3: id_funct3, f7: id_funct7_b5,
               ctrl: id_valid ? id_ctrl : 10'd0};
      end
      if (!ex_flush && !ex_hold && m_lu && m_stall < STAT_MAXI) m_stall <= m_stall + 1;
      if (ex_flush && (m.v || id_valid) && m_flush < STAT_MAXI) m_flush <= m_flush + 1;
    end
  end

  // Per-cycle compare; data fields are only meaningful for a valid EX instruction.
  always @(negedge clk) begin
    chk("ex_valid", 32'(ex_valid), 32'(m.v));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
    chk("stall_id", 32'(stall_id), 32'(m_stall_id));
    if (m.v) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs1_data", ex_rs1_data, m.a);
      chk("ex_rs2_data", ex_rs2_data, m.b);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
      chk("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
      chk("ex_rd", 32'(ex_rd), 32'(m.rd));
      chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
      chk("ex_funct7_b5", 32'(ex_funct7_b5), 32'(m.f7));
    end
`ifdef HAZARD_STATS_EN
    chk("stat_stall_cnt", 32'(stat_stall_cnt), 32'(m_stall));
    chk("stat_flush_cnt", 32'(stat_flush_cnt), 32'(m_flush));
`endif
  end

  // Drive one ID instruction for one cycle; starts and ends just after a falling edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic [9:0] ctrl,
                      input logic fl, input logic hd);
    id_valid = v;
    id_pc = pc;
    id_rs1_data = pc ^ 32'h1111_0000;
    id_rs2_data = pc + 32'h20;
    id_imm = ~pc;
    id_rs1 = rs1;
    id_rs2 = rs2;
    id_rd = rd;
    id_funct3 = pc[4:2];
    id_funct7_b5 = pc[2];
    id_ctrl = ctrl;
    ex_flush = fl;
    ex_hold = hd;
    #1 last_stall = stall_id;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct3 = 0; id_funct7_b5 = 0; id_ctrl = 0;
    ex_flush = 0; ex_hold = 0; last_stall = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("rst ex_valid", 32'(ex_valid), 32'd0);
    chk("rst stall_id", 32'(stall_id), 32'd0);
    chk("rst ex_pc", ex_pc, 32'd0);

    // Load-use: lw x5 then add x6,x5,x1
    step(1, 32'h100, 5'd2, 5'd3, 5'd5, C_LW, 0, 0);
    chk("lw ex_rd", 32'(ex_rd), 32'd5);
    chk("lw ex_ctrl", 32'(ex_ctrl), 32'h3A0);
    step(1, 32'h104, 5'd5, 5'd1, 5'd6, C_ADD, 0, 0);
    chk("lu stall_id", 32'(last_stall), 32'd1);
    chk("lu bubble valid", 32'(ex_valid), 32'd0);
    chk("lu bubble ctrl", 32'(ex_ctrl), 32'd0);
    step(1, 32'h104, 5'd5, 5'd1, 5'd6, C_ADD, 0, 0);
    chk("lu release stall", 32'(last_stall), 32'd0);
    chk("lu add ex_rd", 32'(ex_rd), 32'd6);
    chk("lu add ex_ctrl", 32'(ex_ctrl), 32'h202);
    chk("lu add ex_pc", ex_pc, 32'h104);

    // Load to x0 never stalls
    step(1, 32'h200, 5'd2, 5'd3, 5'd0, C_LW, 0, 0);
    step(1, 32'h204, 5'd0, 5'd0, 5'd7, C_ADD, 0, 0);
    chk("x0 stall_id", 32'(last_stall), 32'd0);
    chk("x0 ex_pc", ex_pc, 32'h204);
    chk("x0 ex_valid", 32'(ex_valid), 32'd1);

    // Flush beats load-use
    step(1, 32'h300, 5'd2, 5'd3, 5'd5, C_LW, 0, 0);
    step(1, 32'h304, 5'd5, 5'd1, 5'd6, C_ADD, 1, 0);
    chk("flush stall_id", 32'(last_stall), 32'd0);
    chk("flush ex_valid", 32'(ex_valid), 32'd0);
    chk("flush ex_ctrl", 32'(ex_ctrl), 32'd0);

    // Invalid ID instruction enters EX as a zero-ctrl bubble
    step(0, 32'h380, 5'd1, 5'd2, 5'd3, C_ADD, 0, 0);
    chk("idle ex_ctrl", 32'(ex_ctrl), 32'd0);

    // Hold for three cycles while ID keeps changing
    step(1, 32'h400, 5'd1, 5'd2, 5'd7, C_ADD, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 32'h400 + 32'(4 * i), 5'd1, 5'd2, 5'd8, C_ADD, 0, 1);
      chk("hold stall_id", 32'(last_stall), 32'd1);
      chk("hold ex_pc", ex_pc, 32'h400);
    end
    step(1, 32'h410, 5'd1, 5'd2, 5'd9, C_ADD, 0, 0);
    chk("hold release ex_pc", ex_pc, 32'h410);

    // Hold wins over load-use; hazard re-evaluated after release
    step(1, 32'h500, 5'd2, 5'd3, 5'd5, C_LW, 0, 0);
    step(1, 32'h504, 5'd1, 5'd5, 5'd6, C_ADD, 0, 1);
    chk("hold+lu stall", 32'(last_stall), 32'd1);
    chk("hold+lu ex_ctrl", 32'(ex_ctrl), 32'h3A0);
    step(1, 32'h504, 5'd1, 5'd5, 5'd6, C_ADD, 0, 0);
    chk("post-hold lu stall", 32'(last_stall), 32'd1);
    chk("post-hold bubble", 32'(ex_valid), 32'd0);
    step(1, 32'h504, 5'd1, 5'd5, 5'd6, C_ADD, 0, 0);
    chk("post-hold add pc", ex_pc, 32'h504);

    // Asynchronous reset between edges
    step(1, 32'h580, 5'd1, 5'd2, 5'd3, C_LW, 0, 0);
    chk("pre-rst ex_valid", 32'(ex_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst ex_valid", 32'(ex_valid), 32'd0);
    chk("async rst ex_ctrl", 32'(ex_ctrl), 32'd0);
    id_valid = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;

`ifdef HAZARD_STATS_EN
    // Twenty load-use bubbles saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step(1, 32'h600 + 32'(16 * i), 5'd2, 5'd3, 5'd5, C_LW, 0, 0);
      step(1, 32'h604 + 32'(16 * i), 5'd5, 5'd1, 5'd6, C_ADD, 0, 0);
      step(1, 32'h604 + 32'(16 * i), 5'd5, 5'd1, 5'd6, C_ADD, 0, 0);
    end
    chk("stat_stall sat", 32'(stat_stall_cnt), 32'hF);
    step(1, 32'h900, 5'd2, 5'd3, 5'd5, C_LW, 0, 0);
    step(1, 32'h904, 5'd5, 5'd1, 5'd6, C_ADD, 0, 0);
    chk("stat_stall held", 32'(stat_stall_cnt), 32'hF);
    step(1, 32'h908, 5'd1, 5'd2, 5'd6, C_ADD, 1, 0);
    chk("stat_flush one", 32'(stat_flush_cnt), 32'd1);
`endif

    step(0, 32'h0, 5'd0, 5'd0, 5'd0, 10'd0, 0, 0);
    step(0, 32'h0, 5'd0, 5'd0, 5'd0, 10'd0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
